openram_march_bist: RTL and testbench
=====================================

// Module: openram_march_bist
// PURPOSE
//  Built-in self-test engine that drives the shared SRAM port-0 bus (addr0/din0/web0/wmask0/csb0).
//  It runs a March C- sequence on one selected macro and checks that macro's port-0 read data.
//  Sits upstream of the SRAM macros, beside the scan-chain control logic; a mux in the wrapper picks BIST or control.
//  Results (pass, error count, first failing address/data) are read back over the logic analyzer.
// PARAMETERS
//  ADDR_WIDTH   16    width of addr0 bus
//  DATA_WIDTH   32    width of din0/dout0
//  WMASK_WIDTH  4     width of wmask0
//  MAX_CHIPS    16    number of csb0 lines
//  NUM_WORDS    1024  words tested (addresses 0..NUM_WORDS-1), >=2
//  RD_LAT       1     cycles from the read command edge to the edge where dout0 is sampled (1..3)
// PORTS
//  clk             in   1           SRAM clock, same net as the macros' clk0
//  reset           in   1           synchronous, active-high
//  start           in   1           level; sampled only in IDLE
//  chip_sel        in   4           index of the macro under test; latched at start
//  dout0           in   DATA_WIDTH  read data of the selected macro (muxed externally)
//  addr0           out  ADDR_WIDTH  SRAM address
//  din0            out  DATA_WIDTH  write data
//  web0            out  1           0 = write, 1 = read
//  wmask0          out  WMASK_WIDTH byte write mask
//  csb0            out  MAX_CHIPS   active-low chip selects, one-hot-low
//  busy            out  1           test in progress
//  done            out  1           level; test finished, held until next start
//  pass            out  1           valid when done; 1 = no mismatches
//  err_count       out  16          mismatch count, saturates at 16'hFFFF
//  fail_addr       out  ADDR_WIDTH  address of the first mismatch
//  fail_data       out  DATA_WIDTH  dout0 captured at the first mismatch
//  fail_elem       out  3           March element (0-5) of the first mismatch
// BEHAVIOUR
//  Reset values: csb0 all 1, web0=1, wmask0=0, addr0=0, din0=0, busy=0, done=0, pass=0, err_count=0, fail_*=0.
//  All outputs are registered.
//  FSM: IDLE -> RUN -> DRAIN -> DONE -> (start) RUN.
//  IDLE and DONE both accept start; start while busy is ignored.
//  On start: clear err_count, fail_* and done; latch chip_sel; set busy.
//  The first operation is on the bus in the cycle after start is sampled.
//  Elements, with 0 = all-zeros word and 1 = all-ones word:
//    E0 up(w0)
//    E1 up(r0,w1)
//    E2 up(r1,w0)
//    E3 down(r0,w1)
//    E4 down(r1,w0)
//    E5 up(r0)
//  Up elements walk address 0..NUM_WORDS-1; down elements walk NUM_WORDS-1..0.
//  Elements follow each other back-to-back with no idle cycle.
//  One operation per cycle; for r,w pairs the read and the write go to the same address on consecutive cycles.
//  Total RUN length is exactly 10*NUM_WORDS cycles.
//  Active op: csb0[sel]=0, others 1.
//  Write: web0=0, wmask0 all 1, din0=pattern. Read: web0=1, wmask0=0, din0 holds its last value.
//  Compare pipeline:
//    A read issued in cycle k is compared against its expected pattern on the edge ending cycle k+RD_LAT.
//    The compare pipe carries {valid, addr, elem, expected}, RD_LAT deep.
//  On mismatch:
//    err_count increments (saturating).
//    If it is the first mismatch, capture fail_addr, fail_data=dout0 and fail_elem.
//  DRAIN: csb0 all 1 and web0=1 for RD_LAT cycles so the last compare retires.
//  After DRAIN: busy=0, done=1, pass=(err_count==0).
//  done rises in cycle 10*NUM_WORDS+RD_LAT+1 after the start cycle.
//  Address counter never exceeds NUM_WORDS-1; wrap between elements reloads 0 or NUM_WORDS-1.
//  reset mid-run: the next cycle shows reset values, with csb0 all 1.
//  A pending compare is discarded and no error is counted.
//  start held high continuously: the test re-runs each time DONE is reached (DONE lasts 1 cycle).
// TESTING
//  Clean model, NUM_WORDS=16, RD_LAT=1, chip_sel=3 -> csb0=16'hFFF7 during RUN.
//    done in cycle 162, pass=1, err_count=0.
//  Stuck-at-1 on bit 5 at addr 7 -> err_count=3 (E1, E3, E5 reads), fail_addr=7, fail_elem=1.
//    fail_data=32'h0000_0020, pass=0.
//  Address-decoder alias (addr 2 -> addr 9 write) -> pass=0, fail_elem=1, fail_addr=9.
//  reset asserted at RUN cycle 40 -> next cycle csb0=16'hFFFF, busy=0, err_count=0.
//    Restart then passes.
//  start pulsed during RUN -> ignored; cycle count still 10*NUM_WORDS+RD_LAT+1.
//  RD_LAT=2 with a 2-cycle model -> pass=1.
//    Injected fault gives correct fail_addr (compare alignment check).

Source files
------------

// File: rtl/openram_march_bist_if.sv
`default_nettype none
// ============================================================================
// Module   : openram_march_bist_if
// Brief    : Shared SRAM port-0 bus between the BIST engine and the macros.
// Revision : 1.0 - initial release
// ============================================================================
interface openram_march_bist_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = 4,
    parameter int MAX_CHIPS   = 16
) ();
    logic [ADDR_WIDTH-1:0]  addr0;
    logic [DATA_WIDTH-1:0]  din0;
    logic                   web0;
    logic [WMASK_WIDTH-1:0] wmask0;
    logic [MAX_CHIPS-1:0]   csb0;
    logic [DATA_WIDTH-1:0]  dout0;

    modport master (output addr0, din0, web0, wmask0, csb0, input dout0);
    modport slave  (input addr0, din0, web0, wmask0, csb0, output dout0);
endinterface
`default_nettype wire

// File: rtl/openram_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : openram_march_bist
// Brief    : March C- self-test engine driving SRAM port 0 of one selected macro.
// Revision : 1.0 - initial release
// ============================================================================
module openram_march_bist #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = 4,
    parameter int MAX_CHIPS   = 16,
    parameter int NUM_WORDS   = 1024,
    parameter int RD_LAT      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            chip_sel,
    openram_march_bist_if.master  sram,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [2:0]            fail_elem
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [1:0]            DRAIN_LAST = 2'(RD_LAT - 1);
    localparam logic [MAX_CHIPS-1:0]  CS_ONE     = MAX_CHIPS'(1);

    // Elements 3 and 4 walk downwards; elements 1..4 are read/write pairs.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction
    function automatic logic elem_pair(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    state_t                  state_q, state_d;
    logic [2:0]              elem_q, elem_d;
    logic                    phase_q, phase_d;
    logic [3:0]              sel_q, sel_d;
    logic [1:0]              drain_q, drain_d;
    logic [ADDR_WIDTH-1:0]   addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0]   din0_q, din0_d;
    logic                    web0_q, web0_d;
    logic [WMASK_WIDTH-1:0]  wmask0_q, wmask0_d;
    logic [MAX_CHIPS-1:0]    csb0_q, csb0_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [15:0]             err_q, err_d;
    logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0]   fail_data_q, fail_data_d;
    logic [2:0]              fail_elem_q, fail_elem_d;
    logic                    op_write;

    // Compare pipe: valid, address, element and expected word of each read.
    logic                    pv_q [RD_LAT];
    logic                    pv_d [RD_LAT];
    logic [ADDR_WIDTH-1:0]   pa_q [RD_LAT];
    logic [ADDR_WIDTH-1:0]   pa_d [RD_LAT];
    logic [2:0]              pe_q [RD_LAT];
    logic [2:0]              pe_d [RD_LAT];
    logic [DATA_WIDTH-1:0]   px_q [RD_LAT];
    logic [DATA_WIDTH-1:0]   px_d [RD_LAT];

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        phase_d     = phase_q;
        sel_d       = sel_q;
        drain_d     = drain_q;
        addr0_d     = addr0_q;
        din0_d      = din0_q;
        web0_d      = 1'b1;
        wmask0_d    = '0;
        csb0_d      = '1;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        fail_elem_d = fail_elem_q;

        for (int i = RD_LAT - 1; i > 0; i--) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
            pe_d[i] = pe_q[i-1];
            px_d[i] = px_q[i-1];
        end
        // The op currently on the bus enters the pipe; phase 0 of any non-E0 element is a read.
        pv_d[0] = (state_q == S_RUN) && (elem_q != 3'd0) && !phase_q;
        pa_d[0] = addr0_q;
        pe_d[0] = elem_q;
        px_d[0] = {DATA_WIDTH{(elem_q == 3'd2) || (elem_q == 3'd4)}};

        if (pv_q[RD_LAT-1] && (sram.dout0 != px_q[RD_LAT-1])) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            if (err_q == 16'd0) begin
                fail_addr_d = pa_q[RD_LAT-1];
                fail_data_d = sram.dout0;
                fail_elem_d = pe_q[RD_LAT-1];
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    elem_d      = 3'd0;
                    phase_d     = 1'b0;
                    addr0_d     = '0;
                    sel_d       = chip_sel;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    fail_elem_d = '0;
                end
            end
            S_RUN: begin
                if (elem_pair(elem_q) && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr0_q == (elem_down(elem_q) ? '0 : LAST_ADDR)) begin
                        if (elem_q == 3'd5) begin
                            state_d = S_DRAIN;
                            drain_d = 2'd0;
                        end else begin
                            elem_d  = elem_q + 3'd1;
                            addr0_d = elem_down(elem_q + 3'd1) ? LAST_ADDR : '0;
                        end
                    end else begin
                        addr0_d = elem_down(elem_q) ? addr0_q - ADDR_WIDTH'(1)
                                                    : addr0_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus registers are loaded from the next sequencer state so they stay aligned with it.
        op_write = (elem_d == 3'd0) || (elem_pair(elem_d) && phase_d);
        if (state_d == S_RUN) begin
            csb0_d = ~(CS_ONE << sel_d);
            web0_d = !op_write;
            if (op_write) begin
                wmask0_d = '1;
                din0_d   = {DATA_WIDTH{(elem_d == 3'd1) || (elem_d == 3'd3)}};
            end
        end
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (err_d == 16'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            phase_q     <= 1'b0;
            sel_q       <= '0;
            drain_q     <= '0;
            addr0_q     <= '0;
            din0_q      <= '0;
            web0_q      <= 1'b1;
            wmask0_q    <= '0;
            csb0_q      <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pa_q[i] <= '0;
                pe_q[i] <= '0;
                px_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            phase_q     <= phase_d;
            sel_q       <= sel_d;
            drain_q     <= drain_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            web0_q      <= web0_d;
            wmask0_q    <= wmask0_d;
            csb0_q      <= csb0_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_elem_q <= fail_elem_d;
            pv_q        <= pv_d;
            pa_q        <= pa_d;
            pe_q        <= pe_d;
            px_q        <= px_d;
        end
    end

    assign sram.addr0  = addr0_q;
    assign sram.din0   = din0_q;
    assign sram.web0   = web0_q;
    assign sram.wmask0 = wmask0_q;
    assign sram.csb0   = csb0_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;
    assign fail_elem   = fail_elem_q;
endmodule
`default_nettype wire

// File: tb/tb_openram_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_openram_march_bist
// Brief    : Two BIST instances (read latency 1 and 2) against faulty SRAM models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_openram_march_bist;
    localparam int NW    = 16;
    localparam int TOTAL = 10 * NW;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] chip_sel;

    always #5 clk = ~clk;

    logic        busy_w [2];
    logic        done_w [2];
    logic        pass_w [2];
    logic        web_w [2];
    logic [3:0]  wmask_w [2];
    logic [15:0] err_w [2];
    logic [15:0] csb_w [2];
    logic [15:0] addr_w [2];
    logic [15:0] faddr_w [2];
    logic [31:0] din_w [2];
    logic [31:0] fdata_w [2];
    logic [2:0]  felem_w [2];

    // Fault injected into the memory model: 0 none, 1 stuck-at cell bit, 2 write alias.
    int   cur_sel, fault_kind, f_addr, f_bit, a_src, a_dst;
    logic f_val;
    int   n_checks, n_fail;

    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int LAT = g + 1;
        openram_march_bist_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WMASK_WIDTH(4), .MAX_CHIPS(16)) u_bus_if ();
        openram_march_bist #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WMASK_WIDTH(4), .MAX_CHIPS(16),
                             .NUM_WORDS(NW), .RD_LAT(LAT)) u_dut (
            .clk(clk), .reset(reset), .start(start), .chip_sel(chip_sel), .sram(u_bus_if),
            .busy(busy_w[g]), .done(done_w[g]), .pass(pass_w[g]), .err_count(err_w[g]),
            .fail_addr(faddr_w[g]), .fail_data(fdata_w[g]), .fail_elem(felem_w[g])
        );
        logic [31:0] mem [NW];
        logic [31:0] rp [LAT];
        int          ma;
        logic [31:0] mv;
        assign u_bus_if.dout0 = rp[LAT-1];
        assign csb_w[g]   = u_bus_if.csb0;
        assign web_w[g]   = u_bus_if.web0;
        assign wmask_w[g] = u_bus_if.wmask0;
        assign addr_w[g]  = u_bus_if.addr0;
        assign din_w[g]   = u_bus_if.din0;

        always @(posedge clk) begin
            ma = int'(u_bus_if.addr0);
            for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
            if (!u_bus_if.csb0[cur_sel] && ma < NW) begin
                mv = mem[ma];
                if (!u_bus_if.web0) begin
                    for (int b = 0; b < 4; b++)
                        if (u_bus_if.wmask0[b]) mv[b*8 +: 8] = u_bus_if.din0[b*8 +: 8];
                    mem[ma] <= mv;
                    if (fault_kind == 2 && ma == a_src) mem[a_dst] <= mv;
                end else begin
                    if (fault_kind == 1 && ma == f_addr) mv[f_bit] = f_val;
                    rp[0] <= mv;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // March C- reference: op codes 0=w0 1=w1 2=r0 3=r1, -1 = no second op.
    int ops [6][2] = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
    logic [68:0] exp_bus [$];
    int          exp_err, exp_faddr, exp_felem;
    logic [31:0] exp_fdata;

    function automatic logic [15:0] cs_for(input int s);
        logic [15:0] v;
        v    = '1;
        v[s] = 1'b0;
        return v;
    endfunction

    task automatic build_model(input int sel);
        logic [31:0] m [NW];
        logic [31:0] last_din, v, want;
        int a;
        exp_bus.delete();
        exp_err = 0; exp_faddr = 0; exp_felem = 0; exp_fdata = '0; last_din = '0;
        for (int i = 0; i < NW; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < NW; i++) begin
                a = (e == 3 || e == 4) ? NW - 1 - i : i;
                for (int k = 0; k < 2; k++) begin
                    if (ops[e][k] == 0 || ops[e][k] == 1) begin
                        v = (ops[e][k] == 1) ? 32'hFFFF_FFFF : 32'h0;
                        m[a] = v;
                        if (fault_kind == 2 && a == a_src) m[a_dst] = v;
                        last_din = v;
                        exp_bus.push_back({cs_for(sel), 1'b0, 4'hF, 16'(a), v});
                    end else if (ops[e][k] >= 2) begin
                        v = m[a];
                        if (fault_kind == 1 && a == f_addr) v[f_bit] = f_val;
                        want = (ops[e][k] == 3) ? 32'hFFFF_FFFF : 32'h0;
                        if (v != want) begin
                            if (exp_err == 0) begin
                                exp_faddr = a; exp_felem = e; exp_fdata = v;
                            end
                            exp_err++;
                        end
                        exp_bus.push_back({cs_for(sel), 1'b1, 4'h0, 16'(a), last_din});
                    end
                end
            end
        end
    endtask

    task automatic run_test(input int sel, input int pulse_cyc, input int reset_cyc);
        int done_cyc [2];
        build_model(sel);
        cur_sel  = sel;
        chip_sel = 4'(sel);
        done_cyc = '{0, 0};
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= TOTAL + 12; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (reset_cyc > 0 && c == reset_cyc + 1) begin
                for (int g = 0; g < 2; g++) begin
                    check_eq($sformatf("rst_csb L%0d", g + 1), csb_w[g], 16'hFFFF);
                    check_eq($sformatf("rst_web L%0d", g + 1), web_w[g], 1'b1);
                    check_eq($sformatf("rst_busy L%0d", g + 1), busy_w[g], 1'b0);
                    check_eq($sformatf("rst_err L%0d", g + 1), err_w[g], 16'h0);
                    check_eq($sformatf("rst_done L%0d", g + 1), done_w[g], 1'b0);
                end
                reset = 1'b0;
                return;
            end
            for (int g = 0; g < 2; g++) begin
                if (c <= TOTAL)
                    check_eq($sformatf("bus L%0d c%0d", g + 1, c),
                             {csb_w[g], web_w[g], wmask_w[g], addr_w[g], din_w[g]}, exp_bus[c-1]);
                if (c == 1) check_eq($sformatf("busy L%0d", g + 1), busy_w[g], 1'b1);
                if (c == TOTAL + 1) begin
                    check_eq($sformatf("drain_csb L%0d", g + 1), csb_w[g], 16'hFFFF);
                    check_eq($sformatf("drain_web L%0d", g + 1), web_w[g], 1'b1);
                end
                if (done_w[g] && done_cyc[g] == 0) done_cyc[g] = c;
            end
            if (pulse_cyc > 0 && c == pulse_cyc) start = 1'b1;
            else if (pulse_cyc > 0 && c == pulse_cyc + 1) start = 1'b0;
            if (c == reset_cyc) reset = 1'b1;
            if (done_cyc[0] != 0 && done_cyc[1] != 0) break;
        end
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("done_cycle L%0d", g + 1), done_cyc[g], TOTAL + g + 2);
            check_eq($sformatf("pass L%0d", g + 1), pass_w[g], exp_err == 0);
            check_eq($sformatf("err_count L%0d", g + 1), err_w[g], exp_err);
            check_eq($sformatf("fail_addr L%0d", g + 1), faddr_w[g], exp_faddr);
            check_eq($sformatf("fail_data L%0d", g + 1), fdata_w[g], exp_fdata);
            check_eq($sformatf("fail_elem L%0d", g + 1), felem_w[g], exp_felem);
            check_eq($sformatf("idle_busy L%0d", g + 1), busy_w[g], 1'b0);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1; start = 1'b0; chip_sel = 4'd0; cur_sel = 0;
        fault_kind = 0; f_addr = 0; f_bit = 0; f_val = 1'b0; a_src = 0; a_dst = 1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("reset_bus L%0d", g + 1),
                     {csb_w[g], web_w[g], wmask_w[g], addr_w[g], din_w[g]},
                     {16'hFFFF, 1'b1, 4'h0, 16'h0, 32'h0});
            check_eq($sformatf("reset_status L%0d", g + 1),
                     {busy_w[g], done_w[g], pass_w[g], err_w[g], faddr_w[g], fdata_w[g], felem_w[g]}, '0);
        end
        reset = 1'b0;
        @(negedge clk);

        fault_kind = 0;
        run_test(3, 0, 0);

        fault_kind = 1; f_addr = 7; f_bit = 5; f_val = 1'b1;
        run_test(int'($urandom_range(15)), 0, 0);

        fault_kind = 2; a_src = 2; a_dst = 9;
        run_test(int'($urandom_range(15)), 0, 0);

        fault_kind = 1; f_addr = 7; f_bit = 5; f_val = 1'b1;
        run_test(5, 0, 40);
        @(negedge clk);
        fault_kind = 0;
        run_test(5, 0, 0);

        run_test(0, 57, 0);

        for (int t = 0; t < 6; t++) begin
            fault_kind = int'($urandom_range(2));
            f_addr     = int'($urandom_range(NW - 1));
            f_bit      = int'($urandom_range(31));
            f_val      = 1'($urandom_range(1));
            a_src      = int'($urandom_range(NW - 1));
            a_dst      = (a_src + 1 + int'($urandom_range(NW - 2))) % NW;
            run_test(int'($urandom_range(15)), int'($urandom_range(TOTAL - 2, 2)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
